stopwatch_run_ctrl: RTL and testbench
=====================================

# stopwatch_run_ctrl

Sequencing controller for the stopwatch digit-counter chain: min, seconds-tens, seconds-units, tenths. It synchronises and edge-detects the front-panel buttons and runs the run/pause/lap/done state machine. It drives the chain's `running`, `dir` and `clear_pulse` controls, and stops the chain at the terminal time so it never wraps. It also raises a timed alarm when the terminal time is reached and provides a lap-hold signal for the display freeze register.

## Interface
- `ALARM_TICKS`, 20: number of `tick_100ms` pulses the alarm stays high in DONE (2 s).
- `clk` in 1: system clock; all logic on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `tick_100ms` in 1: one-cycle 100 ms strobe from the shared divider.
- `start_btn`, `stop_btn`, `clear_btn`, `lap_btn` in 1 each: raw, asynchronous, level button inputs.
- `count_down` in 1: direction switch; 1 = count down.
- `digit_min`, `digit_st`, `digit_su`, `digit_tenths` in 4 each: current BCD digits from the counter chain.
- `running` out 1: counter-chain enable, gated with the tick by the parent.
- `dir` out 1: counter direction; 1 = down.
- `clear_pulse` out 1: one-cycle synchronous clear to all digits.
- `lap_hold` out 1: high while the display must show the frozen lap value.
- `alarm` out 1: terminal-time alarm.

## Operation
- Every button and `count_down` passes through a 2-FF synchroniser.
- A button event is the synchronised level high while the previous synchronised sample was low. Each press gives exactly one event, however long it is held.
- Simultaneous events are resolved by priority: clear > stop > start > lap.
- Terminal condition:
  - `dir`=1: all four digits = 0.
  - `dir`=0: digits = 9,5,9,9 (9:59.9).
- States and outputs:
  - IDLE: running=0, lap_hold=0, alarm=0. `dir` follows synchronised `count_down` every cycle. Start → RUN, unless the terminal condition is already true; then the start is ignored and the state stays IDLE.
  - RUN: running=1. Stop → PAUSE. Lap → LAP. Terminal → DONE.
  - LAP: running=1, lap_hold=1. Lap → RUN. Stop → PAUSE. Terminal → DONE. lap_hold drops on any exit.
  - PAUSE: running=0. Start → RUN, unless terminal. Lap is ignored.
  - DONE: running=0 and alarm=1 until ALARM_TICKS ticks have been counted, then alarm=0. The state stays DONE. Start, stop and lap are ignored.
- Clear, from any state: `clear_pulse`=1 for one cycle, running=0, next state IDLE, alarm counter reset.
- `dir` is frozen outside IDLE. Moving the switch while counting has no effect.
- Alarm counter: $clog2(ALARM_TICKS+1) bits. It counts only in DONE while alarm=1 and saturates.

## Timing
- Reset (asynchronous assertion, mid-operation included): state IDLE; running, dir, clear_pulse, lap_hold and alarm all 0; synchronisers and alarm counter 0. Outputs go low without waiting for a clock edge.
- Button latency: a button first sampled high at edge N changes the registered outputs at edge N+2. The event is seen combinationally after edge N+1.
- `clear_pulse` is registered and high for exactly one cycle.
- Terminal detection is registered. `running` falls one cycle after the digits reach terminal. This is always before the next `tick_100ms`, so the chain never wraps.
- Alarm falls on the clock after the ALARM_TICKS-th tick counted in DONE.

## Configuration
- `STOPWATCH_LAP_EN` defined: `lap_btn` synchroniser, LAP state and `lap_hold` logic are present as described above.
- `STOPWATCH_LAP_EN` undefined: LAP state removed, `lap_btn` ignored, `lap_hold` tied to 0. All other behaviour is identical.

## Test plan
- Up count, lap, stop:
  - Stimulus: reset, count_down=0, press start, run 25 ticks, press lap, run 10 ticks, press lap, press stop.
  - Required: running=1 within 2 cycles of start. lap_hold=1 exactly between the two lap presses. running=0 after stop. Digits 0,3,5 (3.5 s).
- Down terminal:
  - Stimulus: count_down=1, digits at zero, press start.
  - Required: start ignored, running stays 0.
  - Stimulus: with digits 0,0,0,3 press start.
  - Required: after 3 ticks the digits read 0 and running=0 within 1 cycle. alarm=1 for exactly 20 ticks. The state stays DONE until clear.
- Up saturation:
  - Stimulus: run up from 9,5,9,8.
  - Required: after 1 tick the digits read 9,5,9,9, running drops, and no wrap to 0 occurs.
- Simultaneous events:
  - Stimulus: clear and start in the same cycle while in RUN.
  - Required: one clear_pulse, state IDLE, running=0.
  - Stimulus: stop and lap together in RUN.
  - Required: PAUSE with lap_hold=0.
- Async reset mid-alarm:
  - Stimulus: assert rst_n=0 in DONE with alarm=1, between clock edges.
  - Required: alarm and running are 0 immediately. After release, a start counts up from IDLE.
- Macro off:
  - Stimulus: build without `STOPWATCH_LAP_EN`, press lap in RUN.
  - Required: lap_hold stays 0 and running stays 1.

Source files
------------

// File: rtl/stopwatch_run_ctrl.sv
// -----------------------------------------------------------------------------
// stopwatch_run_ctrl
//
// Sequencing controller for the stopwatch digit-counter chain
// (min : sec-tens sec-units . tenths).  Synchronises and edge-detects the
// front-panel buttons, runs the IDLE/RUN/LAP/PAUSE/DONE state machine, stops
// the chain at the terminal time (0:00.0 counting down, 9:59.9 counting up),
// raises a timed alarm on reaching it and provides the lap-hold control for
// the display freeze register.
//
// Optional feature macro: STOPWATCH_LAP_EN
//   defined   : lap_btn synchroniser, LAP state and lap_hold are built.
//   undefined : no LAP state, lap_btn ignored, lap_hold tied low.
//
// Parameters
//   ALARM_TICKS  : number of tick_100ms pulses the alarm stays high in DONE.
//
// Ports
//   clk                       in  : system clock, rising edge
//   rst_n                     in  : asynchronous active-low reset
//   tick_100ms                in  : one-cycle 100 ms strobe
//   start_btn/stop_btn/
//   clear_btn/lap_btn         in  : raw asynchronous button levels
//   count_down                in  : direction switch, 1 = count down
//   digit_min/st/su/tenths    in  : current BCD digits of the chain
//   running                   out : chain enable (parent gates it with the tick)
//   dir                       out : chain direction, 1 = down
//   clear_pulse               out : one-cycle clear of all digits
//   lap_hold                  out : display shows the frozen lap value
//   alarm                     out : terminal-time alarm
// -----------------------------------------------------------------------------
module stopwatch_run_ctrl #(
   parameter int ALARM_TICKS = 20
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       tick_100ms,
   input  logic       start_btn,
   input  logic       stop_btn,
   input  logic       clear_btn,
   input  logic       lap_btn,
   input  logic       count_down,
   input  logic [3:0] digit_min,
   input  logic [3:0] digit_st,
   input  logic [3:0] digit_su,
   input  logic [3:0] digit_tenths,
   output logic       running,
   output logic       dir,
   output logic       clear_pulse,
   output logic       lap_hold,
   output logic       alarm
);

   // Input channel map.  Channel 0 is the direction switch (level only);
   // the remaining channels are buttons and get an edge detector.
`ifdef STOPWATCH_LAP_EN
   localparam int NCH    = 5;
   localparam int CH_LAP = 4;
`else
   localparam int NCH    = 4;
`endif
   localparam int CH_CD  = 0;
   localparam int CH_CLR = 1;
   localparam int CH_STP = 2;
   localparam int CH_STA = 3;

   localparam int              CW        = $clog2(ALARM_TICKS + 1);
   localparam logic [CW-1:0]   ALARM_MAX = CW'(ALARM_TICKS);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RUN,
      S_PAUSE,
      S_DONE
`ifdef STOPWATCH_LAP_EN
      , S_LAP
`endif
   } state_t;

   // ---------------------------------------------------------------------
   // Synchronisers and edge detectors
   // ---------------------------------------------------------------------
   logic [NCH-1:0] raw_in;
   logic [NCH-1:0] sync_lvl;
   logic [NCH-1:1] evt;

`ifdef STOPWATCH_LAP_EN
   assign raw_in = {lap_btn, start_btn, stop_btn, clear_btn, count_down};
`else
   assign raw_in = {start_btn, stop_btn, clear_btn, count_down};
   logic unused_lap_btn;
   assign unused_lap_btn = lap_btn;
`endif

   genvar gi;
   generate
      for (gi = 0; gi < NCH; gi++) begin : g_sync
         logic s1_reg;
         logic s2_reg;
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               s1_reg <= 1'b0;
               s2_reg <= 1'b0;
            end else begin
               s1_reg <= raw_in[gi];
               s2_reg <= s1_reg;
            end
         end
         assign sync_lvl[gi] = s2_reg;
      end

      // One event per press: synchronised level high, previous sample low.
      for (gi = 1; gi < NCH; gi++) begin : g_edge
         logic prev_reg;
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               prev_reg <= 1'b0;
            end else begin
               prev_reg <= sync_lvl[gi];
            end
         end
         assign evt[gi] = sync_lvl[gi] & ~prev_reg;
      end
   endgenerate

   logic cd_sync;
   logic clr_evt;
   logic stp_evt;
   logic sta_evt;
   assign cd_sync = sync_lvl[CH_CD];
   assign clr_evt = evt[CH_CLR];
   assign stp_evt = evt[CH_STP];
   assign sta_evt = evt[CH_STA];
`ifdef STOPWATCH_LAP_EN
   logic lap_evt;
   assign lap_evt = evt[CH_LAP];
`endif

   // ---------------------------------------------------------------------
   // Terminal-time detection on the packed BCD digits
   // ---------------------------------------------------------------------
   logic [15:0] digits_bcd;
   logic        term;
   assign digits_bcd = {digit_min, digit_st, digit_su, digit_tenths};

   // dir_reg is declared below; the terminal value depends on the frozen
   // direction, not the live switch.
   logic dir_reg;
   assign term = dir_reg ? (digits_bcd == 16'h0000) : (digits_bcd == 16'h9599);

   // ---------------------------------------------------------------------
   // State machine
   // ---------------------------------------------------------------------
   state_t        state_reg;
   state_t        state_next;
   logic [CW-1:0] cnt_reg;
   logic [CW-1:0] cnt_next;
   logic          running_reg;
   logic          running_next;
   logic          alarm_reg;
   logic          alarm_next;
   logic          clear_pulse_reg;
`ifdef STOPWATCH_LAP_EN
   logic          lap_hold_reg;
   logic          lap_hold_next;
`endif

   always_comb begin
      state_next   = state_reg;
      cnt_next     = cnt_reg;
      running_next = 1'b0;
      alarm_next   = 1'b0;
`ifdef STOPWATCH_LAP_EN
      lap_hold_next = 1'b0;
`endif

      if (clr_evt) begin
         state_next = S_IDLE;
         cnt_next   = '0;
      end else begin
         case (state_reg)
            S_IDLE, S_PAUSE: begin
               // A start at the terminal time would wrap the chain: ignore it.
               if (sta_evt && !term) state_next = S_RUN;
            end
            S_RUN: begin
               if (stp_evt)      state_next = S_PAUSE;
               else if (term)    state_next = S_DONE;
`ifdef STOPWATCH_LAP_EN
               else if (lap_evt) state_next = S_LAP;
`endif
            end
`ifdef STOPWATCH_LAP_EN
            S_LAP: begin
               if (stp_evt)      state_next = S_PAUSE;
               else if (term)    state_next = S_DONE;
               else if (lap_evt) state_next = S_RUN;
            end
`endif
            S_DONE: begin
               if (tick_100ms && (cnt_reg < ALARM_MAX)) cnt_next = cnt_reg + 1'b1;
            end
            default: state_next = S_IDLE;
         endcase
      end

      // Outputs are registered from the next state so that a button event
      // or terminal condition shows on the outputs at the following edge.
      running_next = (state_next == S_RUN);
`ifdef STOPWATCH_LAP_EN
      if (state_next == S_LAP) running_next = 1'b1;
      lap_hold_next = (state_next == S_LAP);
`endif
      alarm_next = (state_next == S_DONE) && (cnt_next < ALARM_MAX);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg       <= S_IDLE;
         cnt_reg         <= '0;
         dir_reg         <= 1'b0;
         running_reg     <= 1'b0;
         alarm_reg       <= 1'b0;
         clear_pulse_reg <= 1'b0;
      end else begin
         state_reg       <= state_next;
         cnt_reg         <= cnt_next;
         running_reg     <= running_next;
         alarm_reg       <= alarm_next;
         clear_pulse_reg <= clr_evt;
         // Direction is only sampled while idle; it is frozen once counting.
         if (state_reg == S_IDLE) dir_reg <= cd_sync;
      end
   end

`ifdef STOPWATCH_LAP_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lap_hold_reg <= 1'b0;
      end else begin
         lap_hold_reg <= lap_hold_next;
      end
   end
   assign lap_hold = lap_hold_reg;
`else
   assign lap_hold = 1'b0;
`endif

   assign running     = running_reg;
   assign dir         = dir_reg;
   assign clear_pulse = clear_pulse_reg;
   assign alarm       = alarm_reg;

endmodule

// File: tb/tb_stopwatch_run_ctrl.sv
// -----------------------------------------------------------------------------
// tb_stopwatch_run_ctrl
//
// Drives stopwatch_run_ctrl with directed scenarios followed by randomised
// button activity.  The counter chain is modelled as a single integer count
// of tenths (0..5999) and converted to BCD digits for the DUT.  The reference
// model keeps a short sample history per input instead of flip-flops and
// predicts all five outputs after every clock edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_stopwatch_run_ctrl;

   localparam int ALARM_TICKS = 20;
   localparam int TICK_PERIOD = 5;
   localparam int T_MAX       = 5999;   // 9:59.9 in tenths

   localparam int M_IDLE  = 0;
   localparam int M_RUN   = 1;
   localparam int M_LAP   = 2;
   localparam int M_PAUSE = 3;
   localparam int M_DONE  = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       tick_100ms = 1'b0;
   logic       start_btn = 1'b0;
   logic       stop_btn = 1'b0;
   logic       clear_btn = 1'b0;
   logic       lap_btn = 1'b0;
   logic       count_down = 1'b0;
   logic [3:0] digit_min = 4'd0;
   logic [3:0] digit_st = 4'd0;
   logic [3:0] digit_su = 4'd0;
   logic [3:0] digit_tenths = 4'd0;
   logic       running;
   logic       dir;
   logic       clear_pulse;
   logic       lap_hold;
   logic       alarm;

   stopwatch_run_ctrl #(.ALARM_TICKS(ALARM_TICKS)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .tick_100ms   (tick_100ms),
      .start_btn    (start_btn),
      .stop_btn     (stop_btn),
      .clear_btn    (clear_btn),
      .lap_btn      (lap_btn),
      .count_down   (count_down),
      .digit_min    (digit_min),
      .digit_st     (digit_st),
      .digit_su     (digit_su),
      .digit_tenths (digit_tenths),
      .running      (running),
      .dir          (dir),
      .clear_pulse  (clear_pulse),
      .lap_hold     (lap_hold),
      .alarm        (alarm)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   int m_mode;
   bit m_dir;
   bit m_clr;
   int m_alarm_ticks;
   int t_now;              // chain value in tenths of a second
   bit hist [5][4];        // per input: samples at edges e, e-1, e-2, e-3
   int tick_ctr = 0;

   function automatic bit model_running();
      return (m_mode == M_RUN) || (m_mode == M_LAP);
   endfunction

   function automatic bit model_alarm();
      return (m_mode == M_DONE) && (m_alarm_ticks < ALARM_TICKS);
   endfunction

   task automatic model_reset();
      m_mode = M_IDLE;
      m_dir = 1'b0;
      m_clr = 1'b0;
      m_alarm_ticks = 0;
      for (int c = 0; c < 5; c++)
         for (int k = 0; k < 4; k++) hist[c][k] = 1'b0;
   endtask

   task automatic model_edge();
      bit samp [5];
      bit ev [5];
      bit term;
      bit was_run;
      bit old_dir;
      bit old_clr;
      samp = '{count_down, clear_btn, stop_btn, start_btn, lap_btn};
      for (int c = 0; c < 5; c++) begin
         hist[c][3] = hist[c][2];
         hist[c][2] = hist[c][1];
         hist[c][1] = hist[c][0];
         hist[c][0] = samp[c];
         // A sample needs two edges to cross the synchroniser.
         ev[c] = hist[c][2] && !hist[c][3];
      end
`ifndef STOPWATCH_LAP_EN
      ev[4] = 1'b0;
`endif
      term    = m_dir ? (t_now == 0) : (t_now == T_MAX);
      was_run = model_running();
      old_dir = m_dir;
      old_clr = m_clr;

      if (m_mode == M_IDLE) m_dir = hist[0][2];
      m_clr = ev[1];
      if (ev[1]) begin
         m_mode = M_IDLE;
         m_alarm_ticks = 0;
      end else begin
         case (m_mode)
            M_IDLE, M_PAUSE: if (ev[3] && !term) m_mode = M_RUN;
            M_RUN: begin
               if (ev[2])      m_mode = M_PAUSE;
               else if (term)  m_mode = M_DONE;
               else if (ev[4]) m_mode = M_LAP;
            end
            M_LAP: begin
               if (ev[2])      m_mode = M_PAUSE;
               else if (term)  m_mode = M_DONE;
               else if (ev[4]) m_mode = M_RUN;
            end
            M_DONE: if (tick_100ms && m_alarm_ticks < ALARM_TICKS) m_alarm_ticks++;
            default: ;
         endcase
      end

      // Counter chain reacts to the controls that were present at this edge.
      if (old_clr) t_now = 0;
      else if (tick_100ms && was_run) t_now = t_now + (old_dir ? -1 : 1);
   endtask

   task automatic drive_digits();
      digit_min    = 4'(t_now / 600);
      digit_st     = 4'((t_now % 600) / 100);
      digit_su     = 4'((t_now % 100) / 10);
      digit_tenths = 4'(t_now % 10);
   endtask

   task automatic compare_outputs(input string phase);
      check({phase, ".running"},     {31'd0, running},     {31'd0, model_running()});
      check({phase, ".dir"},         {31'd0, dir},         {31'd0, m_dir});
      check({phase, ".clear_pulse"}, {31'd0, clear_pulse}, {31'd0, m_clr});
      check({phase, ".lap_hold"},    {31'd0, lap_hold},    {31'd0, (m_mode == M_LAP)});
      check({phase, ".alarm"},       {31'd0, alarm},       {31'd0, model_alarm()});
   endtask

   string phase = "reset";

   task automatic step();
      tick_100ms = (tick_ctr == 0);
      tick_ctr = (tick_ctr + 1) % TICK_PERIOD;
      @(posedge clk);
      #1;
      if (!rst_n) model_reset();
      else model_edge();
      drive_digits();
      compare_outputs(phase);
   endtask

   task automatic run(input int n);
      repeat (n) step();
   endtask

   task automatic press(input bit s, input bit p, input bit c, input bit l);
      start_btn = s; stop_btn = p; clear_btn = c; lap_btn = l;
      run(3);
      start_btn = 0; stop_btn = 0; clear_btn = 0; lap_btn = 0;
      run(3);
   endtask

   initial begin
      model_reset();
      t_now = 0;
      drive_digits();

      // Reset state
      run(3);
      rst_n = 1'b1;

      // Up count, lap, stop
      phase = "up_lap";
      count_down = 1'b0;
      run(4);
      press(1, 0, 0, 0);
      run(25 * TICK_PERIOD);
      press(0, 0, 0, 1);
      run(10 * TICK_PERIOD);
      press(0, 0, 0, 1);
      press(0, 1, 0, 0);
      run(10);

      // Down terminal: start ignored at zero, then count down 3 ticks
      phase = "down_term";
      press(0, 0, 1, 0);
      count_down = 1'b1;
      run(4);
      t_now = 0;
      drive_digits();
      press(1, 0, 0, 0);
      run(10);
      t_now = 3;
      drive_digits();
      press(1, 0, 0, 0);
      run(30 + ALARM_TICKS * TICK_PERIOD);
      press(1, 0, 0, 0);         // ignored in DONE
      run(5);

      // Up saturation at 9:59.9
      phase = "up_sat";
      press(0, 0, 1, 0);
      count_down = 1'b0;
      run(4);
      t_now = T_MAX - 1;
      drive_digits();
      press(1, 0, 0, 0);
      run(30);

      // Simultaneous events
      phase = "simul";
      press(0, 0, 1, 0);
      run(4);
      press(1, 0, 0, 0);
      run(10);
      press(1, 0, 1, 0);         // clear beats start
      run(5);
      press(1, 0, 0, 0);
      run(10);
      press(0, 1, 0, 1);         // stop beats lap
      run(5);

      // Asynchronous reset while the alarm is on
      phase = "async_rst";
      press(0, 0, 1, 0);
      count_down = 1'b1;
      run(4);
      t_now = 2;
      drive_digits();
      press(1, 0, 0, 0);
      run(3 * TICK_PERIOD + 10);
      check("pre_rst.alarm_on", {31'd0, alarm}, 32'd1);
      #3 rst_n = 1'b0;
      #1;
      check("async_rst.running", {31'd0, running}, 32'd0);
      check("async_rst.alarm",   {31'd0, alarm},   32'd0);
      check("async_rst.dir",     {31'd0, dir},     32'd0);
      model_reset();
      count_down = 1'b0;
      run(2);
      rst_n = 1'b1;
      run(4);
      press(1, 0, 0, 0);
      run(20);

      // Randomised button activity
      phase = "random";
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 9)  == 0) start_btn  = ~start_btn;
         if ($urandom_range(0, 14) == 0) stop_btn   = ~stop_btn;
         if ($urandom_range(0, 9)  == 0) lap_btn    = ~lap_btn;
         if ($urandom_range(0, 59) == 0) clear_btn  = ~clear_btn;
         if ($urandom_range(0, 79) == 0) count_down = ~count_down;
         if (m_mode == M_IDLE && $urandom_range(0, 29) == 0) begin
            case ($urandom_range(0, 3))
               0:       t_now = int'($urandom_range(0, 4));
               1:       t_now = T_MAX - int'($urandom_range(0, 4));
               2:       t_now = int'($urandom_range(0, T_MAX));
               default: t_now = 0;
            endcase
            drive_digits();
         end
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
